// File: rtl/ctrl_pkg.sv
// Shared types and constants for the transmit word serializer.
package ctrl_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_NUM_BYTES = 4;
    localparam int TMR_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } ctrl_tx_state_t;

endpackage

// File: rtl/ctrl_cycle_timer.sv
// Clearable / loadable up-counter with a terminal-count compare.
// One instance is shared between the inter-byte gap and the done timeout,
// the owner selects which terminal value applies in the current state.
module ctrl_cycle_timer
    import ctrl_pkg::*;
(
    input  logic             i_Clock,
    input  logic             i_Rst_n,
    input  logic             i_Clear,
    input  logic             i_Load,
    input  logic [TMR_W-1:0] i_Load_Value,
    input  logic             i_Enable,
    input  logic [TMR_W-1:0] i_Terminal,
    output logic             o_At_Terminal
);

    logic [TMR_W-1:0] count;

    // Count register: clear wins over load, load wins over increment.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            count <= '0;
        end else if (i_Clear) begin
            count <= '0;
        end else if (i_Load) begin
            count <= i_Load_Value;
        end else if (i_Enable) begin
            count <= count + TMR_W'(1);
        end
    end

    assign o_At_Terminal = (count == i_Terminal);

endmodule

// File: rtl/ctrl_32_8.sv
// Transmit word serializer: sends a word to the UART TX one byte at a time,
// MSB first, waiting for the transmitter's done pulse between bytes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_Start; word captured on acceptance
// SEND  | o_Tx_DV strobe for the byte held in o_Tx_Byte
// WAIT  | byte outstanding; waiting for i_Tx_Done or timeout
// GAP   | idle spacing before the next byte strobe
// DONE  | one-cycle o_Done pulse, then back to IDLE
module ctrl_32_8
    import ctrl_pkg::*;
#(
    parameter int NUM_BYTES      = DEF_NUM_BYTES,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic                        i_Start,
    input  logic [BYTE_W*NUM_BYTES-1:0] i_Data,
    output logic                        o_Busy,
    output logic                        o_Tx_DV,
    output logic [BYTE_W-1:0]           o_Tx_Byte,
    input  logic                        i_Tx_Done,
    output logic                        o_Done,
    output logic                        o_Error
);

    localparam int DATA_W = BYTE_W * NUM_BYTES;
    localparam int CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] GAP_TC   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMR_W-1:0] TO_TC    = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit USE_GAP = (GAP_CYCLES > 0);
    localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);

    ctrl_tx_state_t    state, state_nxt;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_shift;
    logic [CNT_W-1:0]  cnt;
    logic [BYTE_W-1:0] tx_byte;
    logic              error_q;

    logic              accept, advance, abort;
    logic              tmr_clr, tmr_en, at_tc;
    logic [TMR_W-1:0]  tmr_terminal;

    assign sr_shift = sr << BYTE_W;

    ctrl_cycle_timer u_timer (
        .i_Clock       (i_Clock),
        .i_Rst_n       (i_Rst_n),
        .i_Clear       (tmr_clr),
        .i_Load        (1'b0),
        .i_Load_Value  ({TMR_W{1'b0}}),
        .i_Enable      (tmr_en),
        .i_Terminal    (tmr_terminal),
        .o_At_Terminal (at_tc)
    );

    // State register.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control. A done pulse in WAIT takes priority
    // over a timeout landing in the same cycle.
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        advance      = 1'b0;
        abort        = 1'b0;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;
        tmr_terminal = TO_TC;
        case (state)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (i_Start) begin
                    accept    = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                tmr_clr   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_Tx_Done) begin
                    tmr_clr = 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_nxt = ST_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = USE_GAP ? ST_GAP : ST_SEND;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (TO_EN && at_tc) begin
                        abort     = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                tmr_terminal = GAP_TC;
                tmr_en       = 1'b1;
                if (at_tc) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register, byte counter and output byte. The byte is loaded on
    // the edge that enters SEND so it is valid together with the strobe.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            sr      <= '0;
            cnt     <= '0;
            tx_byte <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= abort;
            if (accept) begin
                sr      <= i_Data;
                cnt     <= '0;
                tx_byte <= i_Data[DATA_W-1 -: BYTE_W];
            end else if (advance) begin
                sr      <= sr_shift;
                cnt     <= cnt + CNT_W'(1);
                tx_byte <= sr_shift[DATA_W-1 -: BYTE_W];
            end else if (abort) begin
                sr  <= '0;
                cnt <= '0;
            end
        end
    end

    assign o_Busy    = (state != ST_IDLE);
    assign o_Tx_DV   = (state == ST_SEND);
    assign o_Done    = (state == ST_DONE);
    assign o_Tx_Byte = tx_byte;
    assign o_Error   = error_q;

endmodule

// File: doc/ctrl_32_8.md
# ctrl_32_8

Transmit-side word serializer: accepts a 32-bit word from the APB/peripheral side and hands it, one byte at a time and MSB first, to the UART transmitter, waiting for the transmitter's completion pulse before issuing each subsequent byte. It is the counterpart of the 8-to-32 receive accumulator. A word sent through `ctrl_32_8` and the UART link is reassembled bit-identically at the far end.

## Interface
Parameters:
- `NUM_BYTES`, 4: bytes per word. Data width is 8*NUM_BYTES.
- `GAP_CYCLES`, 0: idle clocks inserted between a byte's i_Tx_Done and the next o_Tx_DV. 0 means no gap.
- `TIMEOUT_CYCLES`, 65535: maximum clocks to wait for i_Tx_Done before aborting. 0 disables the timeout.

Ports (one clock; reset is synchronous and active-low):
- `i_Clock`  in  1  system clock; all logic on rising edge.
- `i_Rst_n`  in  1  synchronous active-low reset.
- `i_Start`  in  1  request to send `i_Data`; sampled only in IDLE.
- `i_Data`  in  32  word to send; captured on an accepted i_Start.
- `o_Busy`  out  1  high from the cycle after acceptance until return to IDLE.
- `o_Tx_DV`  out  1  one-cycle strobe to the UART TX; `o_Tx_Byte` is valid in this cycle.
- `o_Tx_Byte`  out  8  byte to transmit; holds its value between strobes.
- `i_Tx_Done`  in  1  one-cycle pulse from the UART TX when the byte has finished on the line.
- `o_Done`  out  1  one-cycle pulse when all bytes have completed.
- `o_Error`  out  1  one-cycle pulse on timeout abort.

## Operation
- Registers:
  - shift register `sr[31:0]`
  - byte counter `cnt` (0..NUM_BYTES-1)
  - cycle counter `tmr` (16 bits)
- FSM states: IDLE, SEND, WAIT, GAP, DONE.
- IDLE:
  - On i_Start: sr<=i_Data, cnt<=0, go to SEND.
  - Otherwise stay.
- SEND:
  - o_Tx_DV=1 and o_Tx_Byte<=sr[31:24] (registered, so they appear together).
  - tmr<=0, go to WAIT.
- WAIT:
  - On i_Tx_Done with cnt==NUM_BYTES-1: go to DONE.
  - On i_Tx_Done with cnt<NUM_BYTES-1: sr<=sr<<8, cnt<=cnt+1, tmr<=0, then GAP if GAP_CYCLES>0, else SEND.
  - Otherwise tmr++. If TIMEOUT_CYCLES!=0 and tmr==TIMEOUT_CYCLES-1, pulse o_Error, clear sr and cnt, go to IDLE.
- GAP: tmr++. When tmr==GAP_CYCLES-1, go to SEND.
- DONE: o_Done=1 for exactly one cycle, go to IDLE.
- o_Busy = (state != IDLE).
- Byte order: MSB first, i_Data[31:24], [23:16], [15:8], [7:0].
- Ignored inputs:
  - i_Start outside IDLE (no queueing).
  - i_Tx_Done outside WAIT, including in the SEND cycle itself.
- Reset (i_Rst_n==0 at a rising edge), at any time including mid-word:
  - State goes to IDLE.
  - sr, cnt and tmr clear to 0.
  - o_Tx_DV=0, o_Tx_Byte=8'h00, o_Done=0, o_Error=0, o_Busy=0.
  - No partial byte is re-sent after reset.

## Timing
- i_Start accepted at edge N → o_Busy=1 and o_Tx_DV=1 at N+1 (first byte latency 1 clock).
- i_Tx_Done sampled at edge M, not the last byte:
  - With GAP_CYCLES=0, the next o_Tx_DV is at M+1.
  - Otherwise the next o_Tx_DV is at M+1+GAP_CYCLES.
- Last i_Tx_Done at edge M → o_Done=1 at M+1, o_Busy=0 at M+2. A new i_Start is accepted at M+2 at the earliest.
- o_Tx_DV never asserts on two consecutive cycles and never asserts while a byte is outstanding.
- Timeout fires TIMEOUT_CYCLES clocks after entering WAIT. o_Error and IDLE follow on the next edge.

## Structure
- Shared package `ctrl_pkg`:
  - state enum `ctrl_tx_state_t`
  - `BYTE_W=8`
  - default `NUM_BYTES`
- Sub-module `ctrl_cycle_timer`: loadable/clearable 16-bit up-counter with a terminal-count compare. One instance serves both GAP and timeout.
- The FSM and shift register stay in `ctrl_32_8`.

## Test plan
- Basic send: i_Data=32'hDEADBEEF, i_Start for 1 cycle, TX model returns i_Tx_Done 10 cycles after each o_Tx_DV → bytes DE, AD, BE, EF in order; one o_Done; o_Busy low 2 cycles after the last done.
- Gap: GAP_CYCLES=3, i_Data=32'h01020304 → exactly 4 clocks from each i_Tx_Done to the next o_Tx_DV.
- Ignored inputs:
  - i_Start with 32'hCAFEF00D while busy → ignored; original word completes unchanged.
  - Spurious i_Tx_Done in the SEND cycle → ignored.
- Timeout: TIMEOUT_CYCLES=20, TX model never responds → o_Error pulses 1 cycle after 20 WAIT cycles; o_Done never pulses; next i_Start sends all 4 bytes.
- Reset mid-word: i_Rst_n low after byte 2 → all outputs 0 next cycle; a subsequent send of 32'h12345678 emits 12, 34, 56, 78.
- Back-to-back: i_Start asserted continuously with two words → second word's first o_Tx_DV occurs 3 clocks after the first word's last i_Tx_Done.
